mux2_rr_arbiter: RTL and testbench

//   Upstream select-and-stage block for the 2:1 mux datapath. Merges two

---
 rtl/mux2_rr_arbiter.sv | 87 ++++++++
 tb/tb_mux2_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Two-source valid/ready merger with round-robin arbitration and packet lock,
// feeding a single registered output stage. sel reports the source of the held beat.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_t;

  state_t state;
  logic   prio;  // preferred source in StIdle: 0=A, 1=B
  logic   load;

  always_comb begin
    load    = out_ready | ~out_valid;
    a_ready = 1'b0;
    b_ready = 1'b0;
    // Readys are forced low during reset so nothing is accepted while held.
    if (!rst && load) begin
      case (state)
        StIdle: begin
          a_ready = a_valid & (~prio | ~b_valid);
          b_ready = b_valid & (prio | ~a_valid);
        end
        StLockA: a_ready = a_valid;
        StLockB: b_ready = b_valid;
        default: begin
          a_ready = 1'b0;
          b_ready = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      prio      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sel       <= 1'b0;
    end else if (load) begin
      if (a_ready) begin
        out_data  <= a_data;
        out_last  <= a_last;
        out_valid <= 1'b1;
        sel       <= 1'b0;
        if (a_last) begin
          state <= StIdle;
          prio  <= 1'b1;
        end else begin
          state <= StLockA;
        end
      end else if (b_ready) begin
        out_data  <= b_data;
        out_last  <= b_last;
        out_valid <= 1'b1;
        sel       <= 1'b1;
        if (b_last) begin
          state <= StIdle;
          prio  <= 1'b0;
        end else begin
          state <= StLockB;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a packet-level model checked every cycle,
// plus literal expectations on the sequence of beats delivered downstream.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data, out_data;
  logic       a_valid, a_last, a_ready;
  logic       b_valid, b_last, b_ready;
  logic       out_valid, out_last, out_ready, sel;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] log_q[$];  // {sel, data} of beats taken downstream

  mux2_rr_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the output (-1 none), who is preferred, what the output holds.
  int         m_owner = -1;
  int         m_prio  = 0;
  logic       m_ov = 1'b0, m_ol = 1'b0, m_sel = 1'b0;
  logic [7:0] m_od = 8'h00;

  always @(negedge clk) begin
    int  w;
    bit  load;
    if (rst) begin
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sel", sel, 0);
      m_owner = -1; m_prio = 0; m_ov = 0; m_od = 0; m_ol = 0; m_sel = 0;
    end else begin
      load = out_ready || !m_ov;
      w = -1;
      if (load) begin
        if (m_owner == 0)      w = a_valid ? 0 : -1;
        else if (m_owner == 1) w = b_valid ? 1 : -1;
        else if (a_valid && b_valid) w = m_prio;
        else if (a_valid)      w = 0;
        else if (b_valid)      w = 1;
      end
      chk("a_ready", a_ready, (w == 0) ? 1 : 0);
      chk("b_ready", b_ready, (w == 1) ? 1 : 0);
      chk("out_valid", out_valid, m_ov);
      chk("out_data", out_data, m_od);
      chk("out_last", out_last, m_ol);
      chk("sel", sel, m_sel);
      if (out_valid && out_ready) log_q.push_back({sel, out_data});
      if (load) begin
        if (w >= 0) begin
          m_ov  = 1;
          m_sel = (w == 1);
          m_od  = (w == 1) ? b_data : a_data;
          m_ol  = (w == 1) ? b_last : a_last;
          if (m_ol) begin
            m_owner = -1;
            m_prio  = 1 - w;
          end else begin
            m_owner = w;
          end
        end else begin
          m_ov = 0;
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_last = 0; a_data = 8'h00;
    b_valid = 0; b_last = 0; b_data = 8'h00;
  endtask

  initial begin
    rst = 1; out_ready = 1;
    idle_inputs();
    next(); next();
    rst = 0;
    next();

    // Only B valid while A is preferred: taken at once, visible next cycle.
    log_q.delete();
    b_valid = 1; b_data = 8'h5B; b_last = 1;
    @(negedge clk); chk("ft_b_ready", b_ready, 1);
    next();
    b_valid = 0;
    @(negedge clk);
    chk("ft_out_valid", out_valid, 1);
    chk("ft_sel", sel, 1);
    chk("ft_data", out_data, 8'h5B);
    next(); next();
    chk("ft_n", log_q.size(), 1);

    // Contention with single-beat packets alternates every cycle.
    log_q.delete();
    a_valid = 1; a_data = 8'h11; a_last = 1;
    b_valid = 1; b_data = 8'h22; b_last = 1;
    repeat (4) next();
    idle_inputs();
    next(); next();
    chk("rr_n", log_q.size(), 4);
    chk("rr_0", log_q[0], {1'b0, 8'h11});
    chk("rr_1", log_q[1], {1'b1, 8'h22});
    chk("rr_2", log_q[2], {1'b0, 8'h11});
    chk("rr_3", log_q[3], {1'b1, 8'h22});

    // A three-beat packet holds the grant against a waiting B.
    log_q.delete();
    b_valid = 1; b_data = 8'hB0; b_last = 1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_data = 8'hA0 + 8'(i); a_last = (i == 2);
      @(negedge clk); chk("lock_b_ready", b_ready, 0);
      next();
    end
    a_valid = 0; a_last = 0;
    @(negedge clk); chk("lock_b_turn", b_ready, 1);
    next();
    idle_inputs();
    next(); next();
    chk("lock_n", log_q.size(), 4);
    chk("lock_0", log_q[0], {1'b0, 8'hA0});
    chk("lock_1", log_q[1], {1'b0, 8'hA1});
    chk("lock_2", log_q[2], {1'b0, 8'hA2});
    chk("lock_3", log_q[3], {1'b1, 8'hB0});

    // Backpressure freezes the output stage and blocks both sources.
    log_q.delete();
    a_valid = 1; a_data = 8'hC1; a_last = 1;
    next();
    out_ready = 0;
    a_data = 8'hC2;
    b_valid = 1; b_data = 8'hD1; b_last = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_data", out_data, 8'hC1);
      chk("bp_last", out_last, 1);
      chk("bp_sel", sel, 0);
      chk("bp_readys", {a_ready, b_ready}, 2'b00);
      next();
    end
    out_ready = 1;
    @(negedge clk); chk("bp_release", {a_ready, b_ready}, 2'b01);
    next(); next();
    idle_inputs();
    next(); next();
    chk("bp_n", log_q.size(), 3);
    chk("bp_0", log_q[0], {1'b0, 8'hC1});
    chk("bp_1", log_q[1], {1'b1, 8'hD1});
    chk("bp_2", log_q[2], {1'b0, 8'hC2});

    // A locked source going quiet stalls the block; B waits for the release.
    log_q.delete();
    a_valid = 1; a_data = 8'hE0; a_last = 0;
    next();
    a_valid = 0;
    b_valid = 1; b_data = 8'hF0; b_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_b_ready", b_ready, 0);
      chk("stall_out_valid", out_valid, (i == 0) ? 1 : 0);
      next();
    end
    a_valid = 1; a_data = 8'hE1; a_last = 1;
    next();
    a_valid = 0; a_last = 0;
    next();
    idle_inputs();
    next(); next();
    chk("stall_n", log_q.size(), 3);
    chk("stall_0", log_q[0], {1'b0, 8'hE0});
    chk("stall_1", log_q[1], {1'b0, 8'hE1});
    chk("stall_2", log_q[2], {1'b1, 8'hF0});

    // Reset mid-packet drops it; afterwards A is preferred again.
    a_valid = 1; a_data = 8'h90; a_last = 0;
    next();
    a_data = 8'h91;
    b_valid = 1; b_data = 8'h99; b_last = 0;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_readys", {a_ready, b_ready}, 2'b00);
    next(); next();
    log_q.delete();
    a_data = 8'h70; a_last = 1;
    b_data = 8'h71; b_last = 1;
    rst = 0;
    @(negedge clk); chk("post_rst_a_first", {a_ready, b_ready}, 2'b10);
    next();
    a_valid = 0;
    next();
    idle_inputs();
    next(); next();
    chk("post_rst_n", log_q.size(), 2);
    chk("post_rst_0", log_q[0], {1'b0, 8'h70});
    chk("post_rst_1", log_q[1], {1'b1, 8'h71});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
